// File: rtl/io_port_pkg.sv
// Shared types and constants for the io_port processor I/O peripheral.
package io_port_pkg;

   localparam int BYTE_W = 8;

   // Processor-side 4-phase handshake phases.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } hs_state_t;

   // Occupancy counters must represent 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/io_port_if.sv
// Processor external-bus signals seen by the I/O port.
interface io_port_if;

   logic [io_port_pkg::BYTE_W-1:0] bus_out;  // processor OUT data
   logic                           hs_out;   // processor request strobe
   logic                           cpu_rd;   // 1 = IN, 0 = OUT while hs_out=1
   logic [io_port_pkg::BYTE_W-1:0] bus_in;   // data returned to the processor
   logic                           hs_in;    // acknowledge back to the processor

   // Processor drives the request side.
   modport master (
      output bus_out, hs_out, cpu_rd,
      input  bus_in, hs_in
   );

   // The I/O port answers the request.
   modport slave (
      input  bus_out, hs_out, cpu_rd,
      output bus_in, hs_in
   );

endinterface

// File: rtl/io_port_byte_fifo.sv
// Single-clock byte FIFO with occupancy count; used for both RX and TX.
module byte_fifo
   import io_port_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                          g_clk,
   input  logic                          g_clr,
   input  logic                          push,
   input  logic [BYTE_W-1:0]             data_in,
   input  logic                          pop,
   output logic [BYTE_W-1:0]             data_out,
   output logic                          full,
   output logic                          empty,
   output logic [count_width(DEPTH)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   // Overflow and underflow requests are dropped rather than corrupting state.
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign data_out = empty ? '0 : mem[rd_ptr];

   // Storage write.
   // NOTE: storage is deliberately not reset; data_out is masked while empty, so stale contents never escape.
   always_ff @(posedge g_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
   // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge g_clk) begin
      if (g_clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/io_port.sv
// Handshaking I/O port: processor OUT bytes go to a TX FIFO for the host,
// host bytes arrive through an RX FIFO and are returned on processor IN cycles.
module io_port
   import io_port_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int INT_EN = 1
) (
   input  logic                          g_clk,
   input  logic                          g_clr,
   io_port_if.slave                      cpu,
   output logic                          ext_int,
   input  logic [BYTE_W-1:0]             host_rx_data,
   input  logic                          host_rx_valid,
   output logic                          host_rx_ready,
   output logic [BYTE_W-1:0]             host_tx_data,
   output logic                          host_tx_valid,
   input  logic                          host_tx_ready,
   output logic [count_width(DEPTH)-1:0] rx_count,
   output logic [count_width(DEPTH)-1:0] tx_count
);

   hs_state_t         state_q, state_d;
   logic              hs_in_q, hs_in_d;
   logic [BYTE_W-1:0] bus_in_q, bus_in_d;
   logic              ext_int_q;

   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [BYTE_W-1:0] rx_head;
   logic              tx_push, tx_pop, tx_full, tx_empty;

   assign host_rx_ready = ~rx_full;
   assign rx_push       = host_rx_valid & host_rx_ready;
   assign host_tx_valid = ~tx_empty;
   assign tx_pop        = host_tx_valid & host_tx_ready;

   byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .g_clk    (g_clk),
      .g_clr    (g_clr),
      .push     (rx_push),
      .data_in  (host_rx_data),
      .pop      (rx_pop),
      .data_out (rx_head),
      .full     (rx_full),
      .empty    (rx_empty),
      .count    (rx_count)
   );

   byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .g_clk    (g_clk),
      .g_clr    (g_clr),
      .push     (tx_push),
      .data_in  (cpu.bus_out),
      .pop      (tx_pop),
      .data_out (host_tx_data),
      .full     (tx_full),
      .empty    (tx_empty),
      .count    (tx_count)
   );

   // Handshake next-state logic: one transfer on entry to ACK, release when hs_out drops.
   // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      hs_in_d  = hs_in_q;
      bus_in_d = bus_in_q;
      tx_push  = 1'b0;
      rx_pop   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cpu.hs_out) begin
               if (!cpu.cpu_rd && !tx_full) begin
                  tx_push = 1'b1;
                  hs_in_d = 1'b1;
                  state_d = ST_ACK;
               end else if (cpu.cpu_rd && !rx_empty) begin
                  rx_pop   = 1'b1;
                  bus_in_d = rx_head;
                  hs_in_d  = 1'b1;
                  state_d  = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            // Direction and data are ignored here; only the strobe release matters.
            if (!cpu.hs_out) begin
               hs_in_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            hs_in_d = 1'b0;
         end
      endcase
   end

   // Handshake state and registered processor-facing outputs.
   always_ff @(posedge g_clk) begin
      if (g_clr) begin
         state_q  <= ST_IDLE;
         hs_in_q  <= 1'b0;
         bus_in_q <= '0;
      end else begin
         state_q  <= state_d;
         hs_in_q  <= hs_in_d;
         bus_in_q <= bus_in_d;
      end
   end

   // Interrupt request registered from RX occupancy, so it trails the FIFO by one cycle.
   always_ff @(posedge g_clk) begin
      if (g_clr) begin
         ext_int_q <= 1'b0;
      end else begin
         ext_int_q <= (INT_EN != 0) && (rx_count != '0);
      end
   end

   assign cpu.hs_in  = hs_in_q;
   assign cpu.bus_in = bus_in_q;
   assign ext_int    = ext_int_q;

endmodule

// File: tb/tb_io_port.sv
// Self-checking bench for io_port: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_io_port;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          g_clk = 1'b0;
   logic          g_clr;
   logic          ext_int;
   logic [7:0]    host_rx_data;
   logic          host_rx_valid;
   logic          host_rx_ready;
   logic [7:0]    host_tx_data;
   logic          host_tx_valid;
   logic          host_tx_ready;
   logic [CW-1:0] rx_count;
   logic [CW-1:0] tx_count;

   io_port_if cpu_bus ();

   io_port #(.DEPTH(DEPTH), .INT_EN(1)) dut (
      .g_clk         (g_clk),
      .g_clr         (g_clr),
      .cpu           (cpu_bus),
      .ext_int       (ext_int),
      .host_rx_data  (host_rx_data),
      .host_rx_valid (host_rx_valid),
      .host_rx_ready (host_rx_ready),
      .host_tx_data  (host_tx_data),
      .host_tx_valid (host_tx_valid),
      .host_tx_ready (host_tx_ready),
      .rx_count      (rx_count),
      .tx_count      (tx_count)
   );

   always #5 g_clk = ~g_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Processor side: a transfer happens when a request is seen while not
   // already acknowledged and the resource is available; ack lasts until the
   // strobe is seen low. Host side: plain queues.
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   bit         m_ack    = 1'b0;
   logic [7:0] m_bus_in = 8'h00;
   bit         m_ext    = 1'b0;
   bit         model_ok = 1'b0;

   always @(posedge g_clk) begin
      int  rx_n_before;
      bit  do_out, do_in, do_tx_pop, do_rx_push;
      if (g_clr) begin
         rxq.delete();
         txq.delete();
         m_ack    = 1'b0;
         m_bus_in = 8'h00;
         m_ext    = 1'b0;
         model_ok = 1'b1;
      end else begin
         rx_n_before = rxq.size();
         do_tx_pop   = (txq.size() != 0) && host_tx_ready;
         do_rx_push  = host_rx_valid && (rxq.size() < DEPTH);
         do_out      = 1'b0;
         do_in       = 1'b0;
         if (!m_ack) begin
            if (cpu_bus.hs_out && !cpu_bus.cpu_rd && txq.size() < DEPTH) do_out = 1'b1;
            if (cpu_bus.hs_out &&  cpu_bus.cpu_rd && rxq.size() != 0)    do_in  = 1'b1;
         end else if (!cpu_bus.hs_out) begin
            m_ack = 1'b0;
         end
         if (do_tx_pop) void'(txq.pop_front());
         if (do_in) begin
            m_bus_in = rxq.pop_front();
            m_ack    = 1'b1;
         end
         if (do_out) begin
            txq.push_back(cpu_bus.bus_out);
            m_ack = 1'b1;
         end
         if (do_rx_push) rxq.push_back(host_rx_data);
         m_ext = (rx_n_before != 0);
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge g_clk) begin
      if (model_ok) begin
         check("bus_in",        cpu_bus.bus_in, m_bus_in);
         check("hs_in",         cpu_bus.hs_in,  m_ack);
         check("ext_int",       ext_int,        m_ext);
         check("host_rx_ready", host_rx_ready,  rxq.size() < DEPTH);
         check("host_tx_valid", host_tx_valid,  txq.size() != 0);
         check("host_tx_data",  host_tx_data,   (txq.size() != 0) ? txq[0] : 8'h00);
         check("rx_count",      rx_count,       rxq.size());
         check("tx_count",      tx_count,       txq.size());
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic cpu_out(input logic [7:0] d);
      cpu_bus.bus_out = d;
      cpu_bus.cpu_rd  = 1'b0;
      cpu_bus.hs_out  = 1'b1;
      tick();
      check("out_hs_in_rise", cpu_bus.hs_in, 1'b1);
      cpu_bus.hs_out = 1'b0;
      tick();
      check("out_hs_in_fall", cpu_bus.hs_in, 1'b0);
   endtask

   task automatic cpu_in(input logic [7:0] exp);
      cpu_bus.cpu_rd = 1'b1;
      cpu_bus.hs_out = 1'b1;
      tick();
      check("in_hs_in_rise", cpu_bus.hs_in, 1'b1);
      check("in_bus_in", cpu_bus.bus_in, exp);
      cpu_bus.hs_out = 1'b0;
      tick();
      check("in_hs_in_fall", cpu_bus.hs_in, 1'b0);
   endtask

   task automatic host_push(input logic [7:0] d);
      host_rx_data  = d;
      host_rx_valid = 1'b1;
      tick();
      host_rx_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      g_clr          = 1'b1;
      cpu_bus.bus_out = 8'h00;
      cpu_bus.hs_out  = 1'b0;
      cpu_bus.cpu_rd  = 1'b0;
      host_rx_data   = 8'h00;
      host_rx_valid  = 1'b0;
      host_tx_ready  = 1'b0;
      tick();
      g_clr = 1'b0;

      // Random traffic, then a 2-cycle reset (first reset cycle still has traffic).
      for (int i = 0; i < 40; i++) begin
         cpu_bus.bus_out = 8'($urandom);
         cpu_bus.hs_out  = 1'($urandom);
         cpu_bus.cpu_rd  = 1'($urandom);
         host_rx_data   = 8'($urandom);
         host_rx_valid  = 1'($urandom);
         host_tx_ready  = ($urandom_range(3) == 0);
         tick();
      end
      g_clr = 1'b1;
      tick();
      cpu_bus.hs_out = 1'b0;
      cpu_bus.cpu_rd = 1'b0;
      host_rx_valid  = 1'b0;
      host_tx_ready  = 1'b0;
      tick();
      check("rst_bus_in",   cpu_bus.bus_in, 8'h00);
      check("rst_hs_in",    cpu_bus.hs_in,  1'b0);
      check("rst_ext_int",  ext_int,        1'b0);
      check("rst_rx_ready", host_rx_ready,  1'b1);
      check("rst_tx_valid", host_tx_valid,  1'b0);
      check("rst_rx_count", rx_count,       0);
      check("rst_tx_count", tx_count,       0);
      g_clr = 1'b0;
      tick();

      // OUT of 5A and host drain.
      cpu_bus.bus_out = 8'h5A;
      cpu_bus.cpu_rd  = 1'b0;
      cpu_bus.hs_out  = 1'b1;
      tick();
      check("out5a_hs_in",   cpu_bus.hs_in, 1'b1);
      check("out5a_tx_data", host_tx_data,  8'h5A);
      check("out5a_tx_cnt",  tx_count,      1);
      tick();
      check("out5a_held",    tx_count,      1);
      cpu_bus.hs_out = 1'b0;
      tick();
      check("out5a_hs_fall", cpu_bus.hs_in, 1'b0);
      host_tx_ready = 1'b1;
      tick();
      host_tx_ready = 1'b0;
      check("out5a_drained", tx_count, 0);

      // IN plus interrupt.
      host_push(8'h3C);
      host_push(8'h7E);
      check("in_rx_cnt2", rx_count, 2);
      check("in_ext_on",  ext_int,  1'b1);
      cpu_in(8'h3C);
      cpu_bus.cpu_rd = 1'b1;
      cpu_bus.hs_out = 1'b1;
      tick();
      check("in2_bus_in",  cpu_bus.bus_in, 8'h7E);
      check("in2_rx_cnt",  rx_count,       0);
      check("in2_ext_lag", ext_int,        1'b1);
      cpu_bus.hs_out = 1'b0;
      tick();
      check("in2_ext_off", ext_int, 1'b0);

      // TX full stall.
      for (int i = 1; i <= 4; i++) cpu_out(8'(i));
      check("txfull_cnt", tx_count, 4);
      cpu_bus.bus_out = 8'h05;
      cpu_bus.cpu_rd  = 1'b0;
      cpu_bus.hs_out  = 1'b1;
      tick();
      check("txfull_stall1", cpu_bus.hs_in, 1'b0);
      tick();
      check("txfull_stall2", cpu_bus.hs_in, 1'b0);
      host_tx_ready = 1'b1;
      tick();
      host_tx_ready = 1'b0;
      check("txfull_pop_hs", cpu_bus.hs_in, 1'b0);
      check("txfull_pop_cnt", tx_count, 3);
      tick();
      check("txfull_resume", cpu_bus.hs_in, 1'b1);
      check("txfull_cnt4",   tx_count,      4);
      cpu_bus.hs_out = 1'b0;
      tick();
      host_tx_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         check("txfull_order", host_tx_data, 8'(i));
         tick();
      end
      host_tx_ready = 1'b0;
      check("txfull_empty", tx_count, 0);

      // IN while RX empty with a same-cycle host push: stall one cycle.
      cpu_bus.cpu_rd = 1'b1;
      cpu_bus.hs_out = 1'b1;
      host_rx_data   = 8'h5D;
      host_rx_valid  = 1'b1;
      tick();
      host_rx_valid = 1'b0;
      check("inempty_stall", cpu_bus.hs_in, 1'b0);
      check("inempty_cnt",   rx_count,      1);
      tick();
      check("inempty_go",    cpu_bus.hs_in,  1'b1);
      check("inempty_data",  cpu_bus.bus_in, 8'h5D);
      cpu_bus.hs_out = 1'b0;
      tick();
      tick();

      // Simultaneous RX push and IN pop.
      host_push(8'hAA);
      host_push(8'hBB);
      cpu_bus.cpu_rd = 1'b1;
      cpu_bus.hs_out = 1'b1;
      host_rx_data   = 8'h99;
      host_rx_valid  = 1'b1;
      tick();
      host_rx_valid = 1'b0;
      check("pp_bus_in", cpu_bus.bus_in, 8'hAA);
      check("pp_rx_cnt", rx_count,       2);
      cpu_bus.hs_out = 1'b0;
      tick();
      cpu_in(8'hBB);
      cpu_in(8'h99);

      // RX full: a fifth host byte is refused.
      host_rx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         host_rx_data = 8'(8'hE0 + i);
         tick();
      end
      host_rx_valid = 1'b0;
      check("rxfull_cnt",   rx_count,      4);
      check("rxfull_ready", host_rx_ready, 1'b0);
      for (int i = 0; i < 4; i++) cpu_in(8'(8'hE0 + i));
      tick();

      // Reset mid-handshake, then a fresh transfer from the still-high strobe.
      cpu_bus.bus_out = 8'hC3;
      cpu_bus.cpu_rd  = 1'b0;
      cpu_bus.hs_out  = 1'b1;
      tick();
      check("midrst_ack", cpu_bus.hs_in, 1'b1);
      g_clr = 1'b1;
      tick();
      g_clr = 1'b0;
      check("midrst_hs_in", cpu_bus.hs_in, 1'b0);
      check("midrst_tx",    tx_count,      0);
      tick();
      check("midrst_fresh",   cpu_bus.hs_in, 1'b1);
      check("midrst_tx_data", host_tx_data,  8'hC3);
      check("midrst_tx_cnt",  tx_count,      1);
      cpu_bus.hs_out = 1'b0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/io_port.md
Name: io_port

Overview:
- Handshaking I/O peripheral sitting directly on the processor's external bus.
- Consumes OUT bytes the processor presents on bus_out/hs_out and queues them in a TX FIFO for the host.
- Supplies IN bytes to bus_in/hs_in from an RX FIFO filled by the host.
- Raises ext_int while received data is waiting, so the MHVPIS can vector to an input service routine.

Parameters:
DEPTH, 4, entries per FIFO; power of two, at least 2.
INT_EN, 1, 1 = ext_int driven from RX-not-empty; 0 = ext_int tied low.

Ports:
g_clk  input  1  clock; all state updates on the rising edge.
g_clr  input  1  synchronous, active-high reset.
bus_out  input  8  processor OUT data (R_OUT register).
hs_out  input  1  processor request strobe.
cpu_rd  input  1  transfer direction, valid while hs_out=1; 1 = IN, 0 = OUT. Decoded from the IR opcode at top level.
bus_in  output  8  data to processor RIN; registered.
hs_in  output  1  acknowledge to processor; registered.
ext_int  output  1  interrupt request to MHVPIS input 3.
host_rx_data  input  8  host byte destined for the processor.
host_rx_valid  input  1  host byte valid.
host_rx_ready  output  1  RX FIFO can accept a byte.
host_tx_data  output  8  TX FIFO head byte.
host_tx_valid  output  1  TX FIFO not empty.
host_tx_ready  input  1  host accepts the head byte.
rx_count  output  $clog2(DEPTH)+1  RX occupancy.
tx_count  output  $clog2(DEPTH)+1  TX occupancy.

Behaviour:
- Reset (g_clr=1 at an edge): both FIFOs emptied, FSM to IDLE, bus_in=8'h00, hs_in=0.
  - Resulting outputs: ext_int=0, host_tx_valid=0, host_rx_ready=1, counts=0.
  - Reset overrides every other event in the same cycle, including mid-handshake.
- Host side (valid/ready):
  - RX push when host_rx_valid & host_rx_ready; host_rx_ready = !rx_full (combinational).
  - TX pop when host_tx_valid & host_tx_ready.
  - host_tx_data = TX head (combinational from storage); undefined-free: 8'h00 when empty.
- FIFO rules:
  - Pointers wrap modulo DEPTH.
  - Count goes 0..DEPTH.
  - Push and pop in the same cycle: both performed, count unchanged.
  - Push when full is ignored (cannot occur through ready).
  - Pop when empty is ignored.
- Processor handshake FSM (4-phase), states IDLE, ACK:
  - IDLE, hs_out=1, cpu_rd=0, TX not full: push bus_out into TX, hs_in<=1, go ACK.
  - IDLE, hs_out=1, cpu_rd=0, TX full: stay IDLE, hs_in=0; processor stalls until the host drains TX.
  - IDLE, hs_out=1, cpu_rd=1, RX not empty: bus_in<=RX head, pop RX, hs_in<=1, go ACK. bus_in is valid on the same edge hs_in rises.
  - IDLE, hs_out=1, cpu_rd=1, RX empty: stay IDLE (stall). A host push in that same cycle is seen next cycle.
  - ACK: hold hs_in=1 and bus_in stable until hs_out=0, then hs_in<=0 and go IDLE.
  - cpu_rd and bus_out are ignored in ACK.
  - bus_in retains the last IN byte until the next IN.
- Latency:
  - OUT byte visible on host_tx_data 1 cycle after hs_out is sampled high (TX previously empty).
  - hs_in rises 1 cycle after hs_out is sampled high (resource available).
  - hs_in falls 1 cycle after hs_out is sampled low.
- Exactly one FSM transfer per 4-phase cycle; a held-high hs_out never produces a second transfer.
- ext_int = INT_EN & (rx_count != 0), registered. Deasserts 1 cycle after the pop that empties RX.

Decomposition:
- Shared package io_port_pkg:
  - FSM state enum (IDLE, ACK).
  - Byte width constant 8.
  - Count-width function clog2(DEPTH)+1.
- One natural sub-module: byte_fifo (DEPTH parameter).
  - Ports: push/data_in/pop/data_out/full/empty/count.
  - Instantiated twice, as RX and TX.

Test Plan:
- Reset: hold g_clr 2 cycles after random traffic -> bus_in=00, hs_in=0, ext_int=0, host_rx_ready=1, host_tx_valid=0, counts=0.
- OUT: bus_out=5A, cpu_rd=0, hs_out=1 -> hs_in=1 next cycle, host_tx_data=5A, tx_count=1; drop hs_out -> hs_in=0 next cycle; host_tx_ready=1 -> tx_count=0.
- IN plus interrupt:
  - Host pushes 3C, then 7E -> rx_count=2, ext_int=1.
  - hs_out=1, cpu_rd=1 -> bus_in=3C with hs_in=1.
  - Second IN -> bus_in=7E, ext_int=0 one cycle after the pop.
- TX full stall:
  - DEPTH=4 OUTs 01..04 with host_tx_ready=0, then a 5th OUT of 05 -> hs_in stays 0.
  - Pulse host_tx_ready one cycle -> hs_in=1 the following cycle; TX order 02,03,04,05.
- Simultaneous push/pop: RX count=2, host push 99 in the same cycle as an IN pop -> rx_count remains 2, FIFO order preserved.
- Reset mid-handshake: g_clr in ACK with hs_out=1 -> hs_in=0 next cycle, FSM IDLE; still-high hs_out starts a fresh transfer the cycle after reset releases.
